// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper, default word width.
package uart_pkg;

  localparam int UART_DATA_BITS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  function automatic int baud_ticks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit, with a selectable reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values, giving a true two-stage chain.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit; delivers words over valid/ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BAUD_TICKS = baud_ticks(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF       = BAUD_TICKS / 2;
  localparam int TICK_W     = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam int BIT_W      = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_rx_state_t       r_state;
  uart_rx_state_t       w_state_next;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_rx_s;
  logic                 w_tick_last;
  logic                 w_tick_mid;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx_line),
    .o_q  (w_rx_s)
  );

  assign w_tick_last = (r_tick_cnt == TICK_LAST);
  assign w_tick_mid  = (r_tick_cnt == TICK_MID);

  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_state_next = START;
      START:   if (w_tick_mid) w_state_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_tick_last && (r_bit_cnt == BIT_LAST)) w_state_next = STOP;
      STOP:    if (w_tick_last) w_state_next = w_rx_s ? IDLE : BREAK;
      BREAK:   if (w_rx_s) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_data_valid && data_ready) r_data_valid <= 1'b0;

      case (r_state)
        IDLE, BREAK: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
        end
        START: begin
          r_tick_cnt <= w_tick_mid ? '0 : r_tick_cnt + TICK_W'(1);
        end
        DATA: begin
          if (w_tick_last) begin
            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
            r_tick_cnt <= '0;
          end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end
        STOP: begin
          if (w_tick_last) begin
            r_tick_cnt <= '0;
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
            end else if (!r_data_valid || data_ready) begin
              // A word accepted this very cycle frees the slot for the new one.
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end
        default: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule
